// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - note codes, melody entry type and the two melody tables
package melody_pkg;

    typedef enum logic [3:0] {
        REST = 4'd0,
        C5   = 4'd1,
        D5   = 4'd2,
        E5   = 4'd3,
        F5   = 4'd4,
        G5   = 4'd5,
        A5   = 4'd6,
        B5   = 4'd7,
        C6   = 4'd8
    } note_e;

    typedef struct packed {
        note_e      note;
        logic [2:0] units;
    } entry_t;

    localparam int NOTE_HP_W = 17;
    localparam int IDX_W     = 3;
    localparam int MEL_LEN   = 5;

    localparam entry_t END_ENTRY = '{note: REST, units: 3'd0};

    // Half-period in 100 MHz clocks: round(100e6 / (2 * f_note)).
    function automatic logic [NOTE_HP_W-1:0] note_hp(input note_e code);
        case (code)
            C5:      note_hp = 17'd95557;
            D5:      note_hp = 17'd85131;
            E5:      note_hp = 17'd75843;
            F5:      note_hp = 17'd71586;
            G5:      note_hp = 17'd63776;
            A5:      note_hp = 17'd56818;
            B5:      note_hp = 17'd50619;
            C6:      note_hp = 17'd47778;
            default: note_hp = '0;
        endcase
    endfunction

    localparam entry_t PWR_MELODY [MEL_LEN] = '{
        '{C5, 3'd2}, '{E5, 3'd2}, '{G5, 3'd2}, '{C6, 3'd2}, END_ENTRY
    };

    localparam entry_t COVER_MELODY [MEL_LEN] = '{
        '{G5, 3'd1}, '{E5, 3'd1}, '{C5, 3'd1}, END_ENTRY, END_ENTRY
    };

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - combinational lookup of one melody table entry
module melody_rom
    import melody_pkg::*;
(
    input  logic             melody_id_i,
    input  logic [IDX_W-1:0] idx_i,
    output entry_t           entry_o
);

    // Indices past the table read as the end marker so a wrapped index stops playback.
    always_comb begin
        entry_o = END_ENTRY;
        if (int'(idx_i) < MEL_LEN) begin
            entry_o = melody_id_i ? COVER_MELODY[idx_i] : PWR_MELODY[idx_i];
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - plays a fixed melody as half-period/tone-enable pairs for the PWM stage
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int UNIT_CYCLES = 10_000_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int HP_W        = 17
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_pwr,
    input  logic            start_cover,
    output logic            tone_en,
    output logic [HP_W-1:0] half_period,
    output logic            busy,
    output logic            done,
    output logic            melody_id
);

    localparam int DUR_W = (7 * UNIT_CYCLES > 1) ? $clog2(7 * UNIT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_PRE  = (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 2) : '0;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [DUR_W-1:0] dur_q;
    logic [GAP_W-1:0] gap_q;
    logic [2:0]       units_q;
    logic             mel_q;
    logic             tone_en_q;
    logic [HP_W-1:0]  hp_q;
    logic             busy_q;
    logic             done_q;

    logic             start_any;
    logic             start_sel;
    logic [DUR_W-1:0] dur_last;
    logic             next_is_end;
    entry_t           first_entry;
    entry_t           next_entry;

    assign start_any   = start_pwr | start_cover;
    assign start_sel   = start_cover & ~start_pwr;
    assign dur_last    = DUR_W'(int'(units_q) * UNIT_CYCLES - 1);
    assign next_is_end = (next_entry.units == 3'd0);

    melody_rom u_rom_first (
        .melody_id_i (start_sel),
        .idx_i       ('0),
        .entry_o     (first_entry)
    );

    melody_rom u_rom_next (
        .melody_id_i (mel_q),
        .idx_i       (idx_q + 1'b1),
        .entry_o     (next_entry)
    );

    // done/busy are set one cycle early so they appear during the final gap cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
            units_q   <= '0;
            mel_q     <= 1'b0;
            tone_en_q <= 1'b0;
            hp_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_any) begin
                state_q   <= PLAY;
                mel_q     <= start_sel;
                idx_q     <= '0;
                dur_q     <= '0;
                gap_q     <= '0;
                units_q   <= first_entry.units;
                hp_q      <= HP_W'(note_hp(first_entry.note));
                tone_en_q <= (first_entry.note != REST);
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: ;
                    PLAY: begin
                        if (dur_q == dur_last) begin
                            state_q   <= GAP;
                            gap_q     <= '0;
                            tone_en_q <= 1'b0;
                            hp_q      <= '0;
                            if (GAP_CYCLES == 1 && next_is_end) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            dur_q <= dur_q + 1'b1;
                        end
                    end
                    GAP: begin
                        if (gap_q == GAP_LAST) begin
                            if (next_is_end) begin
                                state_q <= IDLE;
                            end else begin
                                state_q   <= PLAY;
                                idx_q     <= idx_q + 1'b1;
                                dur_q     <= '0;
                                units_q   <= next_entry.units;
                                hp_q      <= HP_W'(note_hp(next_entry.note));
                                tone_en_q <= (next_entry.note != REST);
                            end
                        end else begin
                            gap_q <= gap_q + 1'b1;
                            if (gap_q == GAP_PRE && next_is_end) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tone_en     = tone_en_q;
    assign half_period = hp_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign melody_id   = mel_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - scoreboard bench checking every output change against hand-computed events
module tb_melody_sequencer;

    localparam int UNIT = 100;
    localparam int GAP  = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_pwr = 1'b0;
    logic        start_cover = 1'b0;
    logic        tone_en;
    logic [16:0] half_period;
    logic        busy;
    logic        done;
    logic        melody_id;

    melody_sequencer #(
        .UNIT_CYCLES (UNIT),
        .GAP_CYCLES  (GAP),
        .HP_W        (17)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_pwr   (start_pwr),
        .start_cover (start_cover),
        .tone_en     (tone_en),
        .half_period (half_period),
        .busy        (busy),
        .done        (done),
        .melody_id   (melody_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        te;
        logic [16:0] hp;
        logic        busy;
        logic        done;
        logic        mid;
    } ev_t;

    ev_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic [20:0] prev_out = '0;

    task automatic push_ev(input int c, input logic te, input int hp,
                           input logic b, input logic d, input logic mid);
        ev_t e;
        e.cyc = c; e.te = te; e.hp = 17'(hp); e.busy = b; e.done = d; e.mid = mid;
        exp_q.push_back(e);
    endtask

    // Start sampled at the edge ending cycle t; each note is units*UNIT on, then GAP silent.
    task automatic push_melody(input int t, input logic mid);
        int hp_tab[4];
        int n;
        int u;
        int t0;
        if (mid == 1'b0) begin
            hp_tab = '{95557, 75843, 63776, 47778}; n = 4; u = 2;
        end else begin
            hp_tab = '{63776, 75843, 95557, 0}; n = 3; u = 1;
        end
        t0 = t + 1;
        for (int i = 0; i < n; i++) begin
            push_ev(t0, 1'b1, hp_tab[i], 1'b1, 1'b0, mid);
            push_ev(t0 + u * UNIT, 1'b0, 0, 1'b1, 1'b0, mid);
            t0 = t0 + u * UNIT + GAP;
        end
        push_ev(t0 - 1, 1'b0, 0, 1'b0, 1'b1, mid);
        push_ev(t0, 1'b0, 0, 1'b0, 1'b0, mid);
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if (tone_en !== 1'b0 || half_period !== 17'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got te=%b hp=%0d busy=%b done=%b, want all 0",
                     name, tone_en, half_period, busy, done);
        end
    endtask

    always @(negedge clk) begin
        logic [20:0] cur;
        ev_t e;
        cur = {tone_en, busy, done, melody_id, half_period};
        if (mon_en && cur !== prev_out) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_change: cyc=%0d te=%b hp=%0d busy=%b done=%b id=%b, want no change",
                         cyc, tone_en, half_period, busy, done, melody_id);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.te !== tone_en || e.hp !== half_period ||
                    e.busy !== busy || e.done !== done || e.mid !== melody_id) begin
                    n_err++;
                    $display("FAIL event: got cyc=%0d te=%b hp=%0d busy=%b done=%b id=%b, want cyc=%0d te=%b hp=%0d busy=%b done=%b id=%b",
                             cyc, tone_en, half_period, busy, done, melody_id,
                             e.cyc, e.te, e.hp, e.busy, e.done, e.mid);
                end
            end
        end
        prev_out = cur;
    end

    task automatic sync_cycle(output int t);
        @(posedge clk);
        #1;
        t = cyc;
    endtask

    initial begin
        int t;
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        check_idle("reset_state");
        mon_en = 1'b1;
        repeat (1000) @(posedge clk);
        #1 check_idle("idle_1000");

        // power-on melody
        sync_cycle(t);
        push_melody(t, 1'b0);
        start_pwr = 1'b1;
        @(posedge clk); #1 start_pwr = 1'b0;
        repeat (860) @(posedge clk);

        // cover melody
        sync_cycle(t);
        push_melody(t, 1'b1);
        start_cover = 1'b1;
        @(posedge clk); #1 start_cover = 1'b0;
        repeat (350) @(posedge clk);

        // simultaneous starts: power-on wins
        sync_cycle(t);
        push_melody(t, 1'b0);
        start_pwr = 1'b1; start_cover = 1'b1;
        @(posedge clk); #1 begin start_pwr = 1'b0; start_cover = 1'b0; end
        repeat (860) @(posedge clk);

        // cover preempts power-on 150 cycles in
        sync_cycle(t);
        push_ev(t + 1, 1'b1, 95557, 1'b1, 1'b0, 1'b0);
        push_melody(t + 150, 1'b1);
        start_pwr = 1'b1;
        @(posedge clk); #1 start_pwr = 1'b0;
        while (cyc < t + 150) begin
            @(posedge clk); #1;
        end
        start_cover = 1'b1;
        @(posedge clk); #1 start_cover = 1'b0;
        repeat (360) @(posedge clk);

        // asynchronous reset 50 cycles into a note
        sync_cycle(t);
        push_ev(t + 1, 1'b1, 95557, 1'b1, 1'b0, 1'b0);
        start_pwr = 1'b1;
        @(posedge clk); #1 start_pwr = 1'b0;
        repeat (50) @(posedge clk);
        #1 push_ev(cyc, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1 check_idle("async_reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (300) @(posedge clk);
        #1 check_idle("idle_after_reset");

        repeat (20) @(posedge clk);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_event: got nothing, want cyc=%0d te=%b hp=%0d busy=%b done=%b id=%b",
                     e.cyc, e.te, e.hp, e.busy, e.done, e.mid);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Sits between the debounced/edge-detected button stage and the PWM buzzer stage of the melody player.
- On a one-cycle start request it plays a fixed melody:
  - power-on melody on btnL;
  - open-cover melody on btnR.
- For each note it outputs a half-period value and a tone enable. The PWM stage toggles the buzzer output every half-period while tone enable is high.

Parameters:
- UNIT_CYCLES, 10_000_000, clock cycles per duration unit (100 ms at 100 MHz).
- GAP_CYCLES, 1_000_000, silent cycles inserted after every note (10 ms).
- HP_W, 17, width of the half-period output.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset.
- start_pwr  in  1  single-cycle pulse: play the power-on melody.
- start_cover  in  1  single-cycle pulse: play the open-cover melody.
- tone_en  out  1  high while a note is sounding.
- half_period  out  HP_W  PWM half-period in clocks for the current note; 0 when silent.
- busy  out  1  high from the start acceptance until done.
- done  out  1  one-cycle pulse when a melody completes.
- melody_id  out  1  melody playing or last played: 0 = power-on, 1 = cover.

Behaviour:
- Reset (rst=0, async) forces:
  - state IDLE, all counters 0;
  - tone_en=0, half_period=0, busy=0, done=0, melody_id=0.
  - Reset mid-melody silences the output immediately, with no done pulse.
- Melody table entry = {note code 4b, units 3b}. A units value of 0 marks end of table.
- Note code 0 is a rest: tone_en=0 and half_period=0 for that entry's duration.
- Power-on melody, each note 2 units:
  - C5, half_period 95557;
  - E5, 75843;
  - G5, 63776;
  - C6, 47778.
- Cover melody, each note 1 unit: G5, E5, C5.
- FSM states: IDLE, PLAY, GAP.
  - IDLE -> PLAY on a start pulse.
  - PLAY -> GAP when the duration counter reaches units*UNIT_CYCLES-1.
  - GAP -> PLAY (next entry) when the gap counter reaches GAP_CYCLES-1.
  - GAP -> IDLE when the next entry is the end marker. done=1 for exactly that one cycle; busy drops on the same cycle.
- Latency: a start sampled at edge N gives tone_en=1, the first note's half_period and busy=1 from edge N+1.
- In PLAY, tone_en=1 and half_period = ROM value for the current note.
- In GAP, tone_en=0 and half_period=0.
- Each note occupies exactly units*UNIT_CYCLES + GAP_CYCLES cycles.
- Simultaneous start_pwr and start_cover: power-on wins, melody_id=0.
- A start pulse while busy preempts:
  - the new melody restarts from entry 0 on the next cycle;
  - counters are cleared and no done pulse is issued for the aborted melody.
- Start pulses held high for more than one cycle are the upstream stage's fault. A held level re-triggers every cycle; no filtering here.
- Duration counter width = $clog2(7*UNIT_CYCLES). Gap counter width = $clog2(GAP_CYCLES). The compares must not overflow or wrap.

Decomposition:
- Package melody_pkg holds:
  - note code enum (REST, C5, D5, E5, F5, G5, A5, B5, C6);
  - half-period constant function note_hp(code), computed for 100 MHz;
  - melody entry struct {note, units};
  - the two melody constant arrays with end markers.
- One sub-module: melody_rom. It is combinational, takes (melody_id, index) and returns an entry.
- FSM and counters live in melody_sequencer.

Test Plan (UNIT_CYCLES=100, GAP_CYCLES=10):
- Reset release, no start pulse -> all outputs 0 for 1000 cycles.
- start_pwr pulse at cycle T:
  - T+1: half_period=95557, tone_en=1, busy=1;
  - T+201: tone_en=0 for 10 cycles;
  - T+211: half_period=75843;
  - done pulses at T+840 and busy falls at T+840.
- start_cover pulse:
  - notes are 63776, 75843, 95557, each 100 cycles plus a 10-cycle gap;
  - done after 330 cycles;
  - melody_id=1 throughout.
- start_pwr and start_cover in the same cycle -> melody_id=0, first half_period=95557.
- start_cover pulse 150 cycles into the power-on melody -> next cycle half_period=63776, melody_id=1; no done for the aborted melody; done 330 cycles after the second pulse.
- rst low at cycle 50 of a note -> tone_en, half_period and busy drop to 0 asynchronously, before the next edge. After release, the block stays idle until a new start.
